// File: rtl/mtr_drv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mtr_drv_pkg
// Brief    : Shared types and arithmetic helpers for the multi-channel driver.
// Revision : 1.0 - initial release
// ============================================================================
package mtr_drv_pkg;

    localparam int MAX_W = 32;

    typedef enum logic {
        DRIVE = 1'b0,
        DEAD  = 1'b1
    } ch_state_t;

    // One bit wider than the widest supported duty, so negating the most
    // negative duty and taking differences can never overflow.
    typedef logic signed [MAX_W:0] wide_t;

    function automatic logic [MAX_W-1:0] sat_abs(input wide_t duty, input int unsigned w);
        wide_t lim;
        wide_t mag;
        lim = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        mag = duty[MAX_W] ? -duty : duty;
        if (mag > lim) begin
            mag = lim;
        end
        return mag[MAX_W-1:0];
    endfunction

    // The result always lies between cur and goal, so it stays inside the
    // duty range whenever both inputs do.
    function automatic wide_t slew_toward(input wide_t cur, input wide_t goal, input wide_t step);
        wide_t res;
        res = goal;
        if (step != '0) begin
            if ((goal > cur) && ((goal - cur) > step)) begin
                res = cur + step;
            end else if ((goal < cur) && ((cur - goal) > step)) begin
                res = cur - step;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mtr_ch.sv
`default_nettype none
// ============================================================================
// Module   : mtr_ch
// Brief    : One motor channel: slew-limited duty, reversal dead time, PWM.
// Revision : 1.0 - initial release
// ============================================================================
module mtr_ch
    import mtr_drv_pkg::*;
#(
    parameter int DUTY_W    = 12,
    parameter int SLEW_STEP = 16,
    parameter int DEAD_CYC  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_wrap,
    input  logic [DUTY_W-2:0] i_cnt,
    input  logic [DUTY_W-1:0] i_duty,
    output logic              o_dir,
    output logic              o_pwm,
    output logic              o_dead
);

    localparam int                  c_DCNT_W    = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [c_DCNT_W-1:0] c_DCNT_LOAD = c_DCNT_W'(DEAD_CYC - 1);
    localparam logic [c_DCNT_W-1:0] c_DCNT_ONE  = c_DCNT_W'(1);
    localparam wide_t               c_STEP      = wide_t'(SLEW_STEP);

    logic signed [DUTY_W-1:0] r_tgt;
    logic signed [DUTY_W-1:0] r_cur;
    logic [DUTY_W-2:0]        r_mag_lat;
    logic [c_DCNT_W-1:0]      r_dcnt;
    ch_state_t                r_state;
    logic                     r_dir;
    logic                     r_pwm;
    logic                     r_dead;

    logic                     w_tgt_neg;
    logic                     w_rev;
    wide_t                    w_goal;
    wide_t                    w_cur_next;
    logic [DUTY_W-2:0]        w_mag;

    assign w_tgt_neg  = r_tgt[DUTY_W-1];
    assign w_rev      = (r_tgt != '0) && (w_tgt_neg != r_dir);
    // While a reversal is pending the ramp heads for zero, not the target.
    assign w_goal     = w_rev ? '0 : wide_t'(r_tgt);
    assign w_cur_next = slew_toward(wide_t'(r_cur), w_goal, c_STEP);
    assign w_mag      = (DUTY_W-1)'(sat_abs(w_cur_next, DUTY_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tgt     <= '0;
            r_cur     <= '0;
            r_mag_lat <= '0;
            r_dcnt    <= '0;
            r_state   <= DRIVE;
            r_dir     <= 1'b0;
            r_pwm     <= 1'b0;
            r_dead    <= 1'b0;
        end else begin
            r_tgt <= i_duty;
            if (!i_en) begin
                r_cur     <= '0;
                r_mag_lat <= '0;
                r_dcnt    <= '0;
                r_state   <= DRIVE;
                r_pwm     <= 1'b0;
                r_dead    <= 1'b0;
            end else begin
                case (r_state)
                    DRIVE: begin
                        r_pwm <= (i_cnt < r_mag_lat);
                        if (w_rev && (r_cur == '0)) begin
                            r_state <= DEAD;
                            r_dead  <= 1'b1;
                            r_dcnt  <= c_DCNT_LOAD;
                            r_pwm   <= 1'b0;
                        end else if (i_wrap) begin
                            r_cur     <= DUTY_W'(w_cur_next);
                            r_mag_lat <= w_mag;
                        end
                    end
                    DEAD: begin
                        r_pwm <= 1'b0;
                        if (r_dcnt == '0) begin
                            r_dir   <= w_tgt_neg;
                            r_state <= DRIVE;
                            r_dead  <= 1'b0;
                        end else begin
                            r_dcnt <= r_dcnt - c_DCNT_ONE;
                        end
                    end
                endcase
            end
        end
    end

    assign o_dir  = r_dir;
    assign o_pwm  = r_pwm;
    assign o_dead = r_dead;

endmodule
`default_nettype wire

// File: rtl/mtr_drv_multi.sv
`default_nettype none
// ============================================================================
// Module   : mtr_drv_multi
// Brief    : N-channel motor driver sharing one PWM period counter.
// Revision : 1.0 - initial release
// ============================================================================
module mtr_drv_multi
    import mtr_drv_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int DUTY_W    = 12,
    parameter int SLEW_STEP = 16,
    parameter int DEAD_CYC  = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NUM_CH*DUTY_W-1:0] duty,
    output logic [NUM_CH-1:0]        DIR,
    output logic [NUM_CH-1:0]        PWM,
    output logic [NUM_CH-1:0]        dead
);

    localparam logic [DUTY_W-2:0] c_CNT_MAX = '1;
    localparam logic [DUTY_W-2:0] c_CNT_ONE = (DUTY_W-1)'(1);

    logic [DUTY_W-2:0] r_cnt;
    logic              w_wrap;

    assign w_wrap = (r_cnt == c_CNT_MAX);

    // Free-running regardless of en, so all channels stay period-aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        mtr_ch #(
            .DUTY_W    (DUTY_W),
            .SLEW_STEP (SLEW_STEP),
            .DEAD_CYC  (DEAD_CYC)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_en   (en),
            .i_wrap (w_wrap),
            .i_cnt  (r_cnt),
            .i_duty (duty[g*DUTY_W +: DUTY_W]),
            .o_dir  (DIR[g]),
            .o_pwm  (PWM[g]),
            .o_dead (dead[g])
        );
    end

endmodule
`default_nettype wire

// File: doc/mtr_drv_multi.md
Name: mtr_drv_multi

Overview:
Parametrised N-channel successor to the two-channel motor driver. Each channel takes a signed duty command and outputs a direction bit and a PWM signal. New in this block: per-channel slew-rate limiting, a forced ramp-to-zero plus dead time on every direction reversal, a global enable, and saturation of the most-negative command. Sits between the motion controller and the H-bridge pins.

Parameters:
NUM_CH, 2, number of independent motor channels
DUTY_W, 12, signed duty width; PWM counter width is DUTY_W-1, so period P = 2^(DUTY_W-1) clocks
SLEW_STEP, 16, max |duty| change per PWM period; 0 = no limiting (output jumps straight to target)
DEAD_CYC, 64, clocks of forced-low PWM before DIR flips; must be >=1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  global drive enable
duty  input  NUM_CH*DUTY_W  signed target per channel; channel i at [i*DUTY_W +: DUTY_W]
DIR  output  NUM_CH  direction per channel, 1 = reverse (negative duty)
PWM  output  NUM_CH  PWM per channel
dead  output  NUM_CH  1 while channel is in its DEAD state

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. All flops clear: DIR=0, PWM=0, dead=0, counters=0, cur=0, tgt=0, state=DRIVE.
- Input pipeline: tgt[i] <= duty[i] every clk, giving one cycle of input latency.
- Shared period counter: cnt is DUTY_W-1 bits and counts 0..P-1, then wraps.
- Period boundary: wrap = (cnt == P-1). cur updates and the mag latch take effect only on wrap cycles.
- Magnitude: mag = |cur|, saturated. cur = -2^(DUTY_W-1) gives mag = P-1 and never overflows to 0.
- PWM compare: the mag latch is loaded at wrap. PWM[i] <= (cnt < mag_lat[i]), registered, so PWM lags cnt by one clock.
  - mag_lat = 0 gives PWM constantly 0.
  - mag_lat = P-1 gives PWM high P-1 of every P clocks.
- Per-channel FSM, state DRIVE:
  - On wrap, if sign(tgt) equals DIR or tgt==0: cur moves toward tgt by at most SLEW_STEP and never overshoots.
  - On wrap, if sign(tgt) differs from DIR and cur!=0: cur moves toward 0 by at most SLEW_STEP, clamped at 0.
  - If cur==0 and tgt is nonzero with sign differing from DIR: go to DEAD and load dcnt=DEAD_CYC-1.
- Per-channel FSM, state DEAD:
  - PWM forced 0; dead=1; cur held at 0; dcnt decrements each clk.
  - When dcnt==0: DIR <= sign(tgt), return to DRIVE. Ramping resumes at the next wrap.
  - If tgt changes back to the old sign during DEAD, the dead time still completes and DIR takes sign(tgt) at exit. A DIR flip is therefore always preceded by DEAD_CYC low cycles.
- Arithmetic: step computation uses DUTY_W+1-bit signed intermediates; result is clamped to [-2^(DUTY_W-1), 2^(DUTY_W-1)-1].
- en=0, synchronous, takes effect next clk:
  - cur=0, mag_lat=0, PWM=0; state goes to DRIVE; dead=0; dcnt=0.
  - DIR holds its value; cnt keeps running.
  - When en returns to 1, ramping starts from 0 at the next wrap. The reversal rule still applies if sign(tgt) differs from DIR.
- Reset mid-DEAD or mid-ramp: immediate return to reset values, no partial state kept.
- Channels are fully independent except for the shared cnt.

Decomposition:
- Package mtr_drv_pkg holds:
  - typedef enum logic {DRIVE, DEAD} ch_state_t
  - function sat_abs(signed duty) returning DUTY_W-1 bits
  - function slew_toward(cur, goal, step)
- Sub-module mtr_ch: one channel (tgt flop, FSM, slew, mag latch, PWM flop). It receives cnt and wrap from the top.
- Top level: shared cnt plus a generate loop of NUM_CH mtr_ch instances.

Test Plan:
- Reset: hold rst_n=0 with duty=+500 → DIR=0, PWM=0, dead=0. Release with en=1, SLEW_STEP=0 → PWM high 500 of each 2048-clock period from the second period on.
- Slew ramp: SLEW_STEP=16, step duty 0→+100 → mag_lat goes 16,32,48,64,80,96,100 on successive wraps, then stays at 100.
- Reversal: cur=+32, SLEW_STEP=16, duty→-32 →
  - wrap 1: cur=16; wrap 2: cur=0;
  - DEAD for exactly 64 clocks with PWM=0 and dead=1;
  - then DIR=1, and the next wraps give mag 16, then 32.
- Saturation: SLEW_STEP=0, duty=-2048 → DIR=1 after dead time; PWM high 2047 of 2048 clocks, never stuck low.
- Enable drop: en=0 mid-ramp at cur=+64 → PWM=0 next clk, DIR held. en=1 → ramp restarts 16,32,… from 0.
- Independence: ch0=+300, ch1 reversing +200→-200 → ch0 PWM unaffected while ch1 is in DEAD; async reset asserted during ch1 DEAD clears both channels immediately.
